// File: rtl/agu_pkg.sv
// Shared encodings, exception codes and the queued-op payload for the load/store AGU.
package agu_pkg;

  localparam int OP_STORE_BIT = 3;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

  // Fixed-width part of a queued op; tag and destination widths come from the top.
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] base;
    logic [11:0] imm;
    logic [31:0] data;
  } agu_req_t;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 4'b0001;
      SZ_HALF: return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/agu_fifo.sv
// DEPTH-entry synchronous FIFO with flush; full/empty derive from a registered count.
module agu_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  logic push_i,
  input  T     wr_data_i,
  input  logic pop_i,
  output T     rd_data_o,
  output logic empty_o,
  output logic full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the wrap.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/agu_param.sv
// Load/store AGU: queues issued ops, decodes the head and issues one registered
// load, store or exception pulse per popped op.
module agu_param
  import agu_pkg::*;
#(
  parameter int ROB_W     = 6,
  parameter int DEST_W    = 6,
  parameter int DEPTH     = 2,
  parameter int PHYS_BITS = 32,
  parameter int IO_BIT    = 31
) (
  input  logic              cpu_clock_i,
  input  logic              cpu_reset_i,
  input  logic              flush_i,
  input  logic              lsu_vld_i,
  output logic              lsu_busy_o,
  input  logic [ROB_W-1:0]  lsu_rob_i,
  input  logic [3:0]        lsu_op_i,
  input  logic [31:0]       lsu_base_i,
  input  logic [11:0]       lsu_imm_i,
  input  logic [31:0]       lsu_data_i,
  input  logic [DEST_W-1:0] lsu_dest_i,
  input  logic              lq_full_i,
  output logic              lq_valid_o,
  output logic [31:0]       lq_addr_o,
  output logic [2:0]        lq_ld_type_o,
  output logic [DEST_W-1:0] lq_dest_o,
  output logic [ROB_W-1:0]  lq_rob_o,
  output logic              conflict_vld_o,
  output logic [29:0]       conflict_address_o,
  output logic [3:0]        conflict_bm_o,
  input  logic              enqueue_full_i,
  output logic              enqueue_en_o,
  output logic [29:0]       enqueue_address_o,
  output logic [31:0]       enqueue_data_o,
  output logic [3:0]        enqueue_bm_o,
  output logic              enqueue_io_o,
  output logic [ROB_W-1:0]  enqueue_rob_o,
  output logic              excp_valid_o,
  output logic [31:0]       excp_pc_o,
  output logic [3:0]        excp_code_o,
  output logic [ROB_W-1:0]  excp_rob_o
);

  typedef struct packed {
    logic [ROB_W-1:0]  rob;
    agu_req_t          req;
    logic [DEST_W-1:0] dest;
  } entry_t;

  typedef struct packed {
    logic              lq_valid;
    logic [31:0]       lq_addr;
    logic [2:0]        lq_ld_type;
    logic [DEST_W-1:0] lq_dest;
    logic [ROB_W-1:0]  lq_rob;
    logic              cf_vld;
    logic [29:0]       cf_addr;
    logic [3:0]        cf_bm;
    logic              enq_en;
    logic [29:0]       enq_addr;
    logic [31:0]       enq_data;
    logic [3:0]        enq_bm;
    logic              enq_io;
    logic [ROB_W-1:0]  enq_rob;
    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic [3:0]        ex_code;
    logic [ROB_W-1:0]  ex_rob;
  } out_t;

  entry_t      wr_ent, hd;
  logic        empty, full, pop;
  logic [31:0] ea, st_data;
  logic [3:0]  bm;
  logic        is_st, mis, fault, excp, can_go;
  out_t        out_q, out_d;

  always_comb begin
    wr_ent          = '0;
    wr_ent.rob      = lsu_rob_i;
    wr_ent.req.op   = lsu_op_i;
    wr_ent.req.base = lsu_base_i;
    wr_ent.req.imm  = lsu_imm_i;
    wr_ent.req.data = lsu_data_i;
    wr_ent.dest     = lsu_dest_i;
  end

  agu_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .clk_i     (cpu_clock_i),
    .rst_i     (cpu_reset_i),
    .flush_i   (flush_i),
    .push_i    (lsu_vld_i),
    .wr_data_i (wr_ent),
    .pop_i     (pop),
    .rd_data_o (hd),
    .empty_o   (empty),
    .full_o    (full)
  );

  assign lsu_busy_o = full;

  always_comb begin
    ea      = hd.req.base + {{20{hd.req.imm[11]}}, hd.req.imm};
    is_st   = hd.req.op[OP_STORE_BIT];
    case (size_e'(hd.req.op[1:0]))
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = ea[0];
      SZ_WORD: mis = |ea[1:0];
      default: mis = 1'b1;
    endcase
    fault   = |(ea >> PHYS_BITS);
    excp    = mis | fault;
    bm      = size_mask(hd.req.op[1:0]) << ea[1:0];
    st_data = hd.req.data << {ea[1:0], 3'b000};
    // Exceptions never wait on downstream space; good ops wait on their own queue only.
    can_go  = excp | (is_st ? !enqueue_full_i : !lq_full_i);
    pop     = !empty && !flush_i && !cpu_reset_i && can_go;
  end

  always_comb begin
    out_d          = out_q;
    out_d.lq_valid = 1'b0;
    out_d.cf_vld   = 1'b0;
    out_d.enq_en   = 1'b0;
    out_d.ex_valid = 1'b0;
    if (pop) begin
      if (excp) begin
        out_d.ex_valid = 1'b1;
        out_d.ex_pc    = ea;
        out_d.ex_rob   = hd.rob;
        out_d.ex_code  = is_st ? (mis ? EXC_ST_MISALIGN : EXC_ST_FAULT)
                               : (mis ? EXC_LD_MISALIGN : EXC_LD_FAULT);
      end else if (is_st) begin
        out_d.enq_en   = 1'b1;
        out_d.enq_addr = ea[31:2];
        out_d.enq_data = st_data;
        out_d.enq_bm   = bm;
        out_d.enq_io   = ea[IO_BIT];
        out_d.enq_rob  = hd.rob;
      end else begin
        out_d.lq_valid   = 1'b1;
        out_d.lq_addr    = ea;
        out_d.lq_ld_type = hd.req.op[2:0];
        out_d.lq_dest    = hd.dest;
        out_d.lq_rob     = hd.rob;
        out_d.cf_vld     = 1'b1;
        out_d.cf_addr    = ea[31:2];
        out_d.cf_bm      = bm;
      end
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) out_q <= '0;
    else             out_q <= out_d;
  end

  assign lq_valid_o         = out_q.lq_valid;
  assign lq_addr_o          = out_q.lq_addr;
  assign lq_ld_type_o       = out_q.lq_ld_type;
  assign lq_dest_o          = out_q.lq_dest;
  assign lq_rob_o           = out_q.lq_rob;
  assign conflict_vld_o     = out_q.cf_vld;
  assign conflict_address_o = out_q.cf_addr;
  assign conflict_bm_o      = out_q.cf_bm;
  assign enqueue_en_o       = out_q.enq_en;
  assign enqueue_address_o  = out_q.enq_addr;
  assign enqueue_data_o     = out_q.enq_data;
  assign enqueue_bm_o       = out_q.enq_bm;
  assign enqueue_io_o       = out_q.enq_io;
  assign enqueue_rob_o      = out_q.enq_rob;
  assign excp_valid_o       = out_q.ex_valid;
  assign excp_pc_o          = out_q.ex_pc;
  assign excp_code_o        = out_q.ex_code;
  assign excp_rob_o         = out_q.ex_rob;

endmodule
